hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//   Pipeline hazard controller for the 16-bit five-stage CPU (IF, ID, EX, M, WB).
//   - Detects load-use hazards between the EX and M stage instructions.
//   - Receives jump-taken and force-flush requests.
//   - Drives PC write-enable and per-pipeline-register lock/flush controls.
// PARAMETERS
//   IW      16     instruction width
//   RW      4      register-specifier field width
//   OP_LOAD 4'hC   opcode of load instructions
//   OP_NOP  4'h0   opcode treated as "no source operands"
// PORTS
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-low reset
//   ex_instruction in   16  instruction currently in EX
//   m_instruction  in   16  instruction currently in M
//   force_flush    in   1   external flush request (exception/redirect)
//   jump_taken     in   1   branch/jump resolved taken in EX
//   pc_write       out  1   1 = PC may update this cycle
//   if_id_lock     out  1   hold IF/ID register
//   id_ex_lock     out  1   hold ID/EX register
//   ex_m_lock      out  1   hold EX/M register
//   m_wb_lock      out  1   hold M/WB register
//   if_id_flush    out  1   clear IF/ID to bubble
//   id_ex_flush    out  1   clear ID/EX to bubble
//   ex_m_flush     out  1   clear EX/M to bubble
//   m_wb_flush     out  1   clear M/WB to bubble
// BEHAVIOUR
//   Instruction fields:
//   - opcode = [15:12]; op1 (dest/src A) = [11:8]; op2 (src B) = [7:4]; func = [3:0].
//   Reset:
//   - in_reset flop is set at a posedge where reset==0.
//   - It clears at the first posedge where reset==1.
//   - While in_reset=1: all four *_flush=1, all *_lock=0, pc_write=0.
//   Load-use detection:
//   - load_use = (m.opcode==OP_LOAD) && (ex.opcode!=OP_NOP)
//                && (m.op1==ex.op1 || m.op1==ex.op2).
//   Outside reset, outputs are combinational from current inputs (0-cycle latency).
//   Priority: reset > force_flush > load_use > jump_taken > idle.
//   - force_flush: if_id_flush=id_ex_flush=1, pc_write=1, all locks 0.
//   - load_use (one-bubble stall):
//       - pc_write=0, if_id_lock=id_ex_lock=1, ex_m_flush=1.
//       - M/WB advances normally.
//       - The stall lasts as long as the condition holds; it normally clears after
//         one cycle when the load moves to WB.
//   - jump_taken: if_id_flush=id_ex_flush=1, pc_write=1 (PC loads target).
//   - idle: pc_write=1, all locks and flushes 0.
//   Lock/flush exclusivity:
//   - Never assert lock and flush on the same register.
//   - m_wb_lock and ex_m_lock are 0 in every state; they are reserved ports.
//   Simultaneous events:
//   - jump_taken during a load_use is ignored; the EX instruction re-evaluates next cycle.
//   - force_flush overrides a stall.
//   Reset mid-stall: reset dominates on the next edge; the stall is discarded.
// CONFIGURATION
//   HAZARD_STALL_COUNT_EN defined:
//   - Adds output stall_count[15:0].
//   - Increments on every posedge where load_use is the winning action; saturates at 16'hFFFF.
//   - Cleared to 0 while in_reset.
//   Not defined: no stall_count port and no counter logic.
// STRUCTURE
//   hazard_pkg:
//   - Field position constants (OPC_MSB/LSB, OP1, OP2).
//   - OP_LOAD and OP_NOP.
//   - Typedef/encoding for the action: ACT_RESET, ACT_FLUSH, ACT_STALL, ACT_JUMP, ACT_IDLE.
//   Sub-module hazard_load_use_detect:
//   - Purely combinational.
//   - Inputs: ex_instruction, m_instruction. Output: load_use.
//   Top level: in_reset flop, priority encoder, output decode, optional counter.
// TESTING
//   1. reset=0 for 1 edge -> all flush=1, locks=0, pc_write=0; reset=1 + 1 edge -> idle.
//   2. ex=16'hF050, m=16'hF050 -> idle: pc_write=1, all lock/flush 0.
//   3. Case 2 values + force_flush=1 -> if_id_flush=id_ex_flush=1, pc_write=1, locks 0.
//   4. ex=16'hF050, m=16'hC000 -> pc_write=0, if_id_lock=id_ex_lock=1, ex_m_flush=1.
//      Then m=16'hC100 -> no hazard, idle.
//   5. Case 2 values + jump_taken=1 -> if_id_flush=id_ex_flush=1, pc_write=1.
//      Repeat with m=16'hC000 -> stall wins, no flush of if_id.
//   6. ex=16'h0000, m=16'hC000 -> idle (NOP reads nothing).
//      With HAZARD_STALL_COUNT_EN: 3 stall cycles -> stall_count==3.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_pkg                                                      |
// | Purpose: Shared constants for the hazard controller: instruction field   |
// |          positions, special opcodes and the winning-action encoding.     |
// | Ports  : none (package)                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package hazard_pkg;

  // Instruction field positions for the 16-bit instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OP1_MSB = 11;
  localparam int OP1_LSB = 8;
  localparam int OP2_MSB = 7;
  localparam int OP2_LSB = 4;

  localparam logic [3:0] OP_LOAD = 4'hC;
  localparam logic [3:0] OP_NOP  = 4'h0;

  // Action chosen by the priority encoder, highest priority first
  typedef enum logic [2:0] {
    ACT_RESET = 3'd0,
    ACT_FLUSH = 3'd1,
    ACT_STALL = 3'd2,
    ACT_JUMP  = 3'd3,
    ACT_IDLE  = 3'd4
  } action_t;

endpackage
`default_nettype wire

// File: rtl/hazard_load_use_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_load_use_detect                                          |
// | Purpose: Combinational load-use detector. Flags when the instruction in  |
// |          M is a load whose destination is read by the instruction in EX. |
// | Ports  : ex_instruction [IW-1:0] in  - instruction in EX                 |
// |          m_instruction  [IW-1:0] in  - instruction in M                  |
// |          load_use                out - load-use hazard present           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hazard_load_use_detect
  import hazard_pkg::*;
#(
  parameter int         IW      = 16,
  parameter int         RW      = 4,
  parameter logic [3:0] OP_LD   = OP_LOAD,
  parameter logic [3:0] OP_NONE = OP_NOP
) (
  input  logic [IW-1:0] ex_instruction,
  input  logic [IW-1:0] m_instruction,
  output logic          load_use
);

  logic [3:0]    ex_opc;
  logic [3:0]    m_opc;
  logic [RW-1:0] ex_op1;
  logic [RW-1:0] ex_op2;
  logic [RW-1:0] m_op1;

  assign ex_opc = ex_instruction[OPC_MSB:OPC_LSB];
  assign m_opc  = m_instruction[OPC_MSB:OPC_LSB];
  assign ex_op1 = ex_instruction[OP1_MSB:OP1_LSB];
  assign ex_op2 = ex_instruction[OP2_MSB:OP2_LSB];
  assign m_op1  = m_instruction[OP1_MSB:OP1_LSB];

  // The func field never names a register, so it takes no part in detection
  logic unused_func;
  assign unused_func = ^{ex_instruction[OP2_LSB-1:0], m_instruction[OP2_LSB-1:0],
                         m_instruction[OP2_MSB:OP2_LSB]};

  // A NOP in EX reads no operands, so it can never depend on the load
  assign load_use = (m_opc == OP_LD) && (ex_opc != OP_NONE) &&
                    ((m_op1 == ex_op1) || (m_op1 == ex_op2));

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_unit                                                     |
// | Purpose: Pipeline hazard controller for the 16-bit five-stage CPU.       |
// |          Resolves reset, force-flush, load-use stall and taken jumps by  |
// |          fixed priority and drives PC enable plus register lock/flush.   |
// | Ports  : clk, reset (sync, active-low)                                   |
// |          ex_instruction, m_instruction [IW-1:0] in                       |
// |          force_flush, jump_taken               in                        |
// |          pc_write, *_lock, *_flush             out                       |
// |          stall_count [15:0] out (only with HAZARD_STALL_COUNT_EN)        |
// | Config : `define HAZARD_STALL_COUNT_EN adds a saturating stall counter.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int         IW      = 16,
  parameter int         RW      = 4,
  parameter logic [3:0] OP_LD   = OP_LOAD,
  parameter logic [3:0] OP_NONE = OP_NOP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] ex_instruction,
  input  logic [IW-1:0] m_instruction,
  input  logic          force_flush,
  input  logic          jump_taken,
  output logic          pc_write,
  output logic          if_id_lock,
  output logic          id_ex_lock,
  output logic          ex_m_lock,
  output logic          m_wb_lock,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          ex_m_flush,
`ifdef HAZARD_STALL_COUNT_EN
  output logic          m_wb_flush,
  output logic [15:0]   stall_count
`else
  output logic          m_wb_flush
`endif
);

  logic    in_reset;
  logic    load_use;
  action_t action;

  hazard_load_use_detect #(
    .IW      (IW),
    .RW      (RW),
    .OP_LD   (OP_LD),
    .OP_NONE (OP_NONE)
  ) u_detect (
    .ex_instruction (ex_instruction),
    .m_instruction  (m_instruction),
    .load_use       (load_use)
  );

  // Reset is registered so the bubble-fill state holds for whole cycles
  always_ff @(posedge clk) begin
    if (!reset) in_reset <= 1'b1;
    else        in_reset <= 1'b0;
  end

  always_comb begin
    action = ACT_IDLE;
    if (in_reset)         action = ACT_RESET;
    else if (force_flush) action = ACT_FLUSH;
    else if (load_use)    action = ACT_STALL;
    else if (jump_taken)  action = ACT_JUMP;
  end

  // EX/M and M/WB are never held; their lock ports stay tied low
  assign ex_m_lock = 1'b0;
  assign m_wb_lock = 1'b0;

  always_comb begin
    pc_write    = 1'b1;
    if_id_lock  = 1'b0;
    id_ex_lock  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_flush  = 1'b0;
    m_wb_flush  = 1'b0;
    case (action)
      ACT_RESET: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_m_flush  = 1'b1;
        m_wb_flush  = 1'b1;
      end
      ACT_FLUSH, ACT_JUMP: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ACT_STALL: begin
        // Freeze the front end and inject one bubble behind the load
        pc_write   = 1'b0;
        if_id_lock = 1'b1;
        id_ex_lock = 1'b1;
        ex_m_flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset || in_reset) begin
      stall_count <= 16'd0;
    end else if ((action == ACT_STALL) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_hazard_unit                                                  |
// | Purpose: Directed self-checking bench for hazard_unit.                   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ex_instruction;
  logic [15:0] m_instruction;
  logic        force_flush;
  logic        jump_taken;
  logic        pc_write;
  logic        if_id_lock, id_ex_lock, ex_m_lock, m_wb_lock;
  logic        if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  // {pc_write, if_id_lock, id_ex_lock, ex_m_lock, m_wb_lock,
  //  if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush}
  localparam logic [8:0] EXP_RST   = 9'b0_0000_1111;
  localparam logic [8:0] EXP_IDLE  = 9'b1_0000_0000;
  localparam logic [8:0] EXP_FLUSH = 9'b1_0000_1100;
  localparam logic [8:0] EXP_STALL = 9'b0_1100_0010;

  hazard_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ex_instruction (ex_instruction),
    .m_instruction  (m_instruction),
    .force_flush    (force_flush),
    .jump_taken     (jump_taken),
    .pc_write       (pc_write),
    .if_id_lock     (if_id_lock),
    .id_ex_lock     (id_ex_lock),
    .ex_m_lock      (ex_m_lock),
    .m_wb_lock      (m_wb_lock),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_m_flush     (ex_m_flush),
`ifdef HAZARD_STALL_COUNT_EN
    .m_wb_flush     (m_wb_flush),
    .stall_count    (stall_count)
`else
    .m_wb_flush     (m_wb_flush)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {pc_write, if_id_lock, id_ex_lock, ex_m_lock, m_wb_lock,
            if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply inputs between edges, let combinational logic settle
  task automatic drive(input logic [15:0] ex, input logic [15:0] m,
                       input logic ff, input logic jt);
    ex_instruction = ex;
    m_instruction  = m;
    force_flush    = ff;
    jump_taken     = jt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(16'hF050, 16'hF050, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    #1;
    check("reset_state", 32'(outs()), 32'(EXP_RST));
    drive(16'hF050, 16'hC000, 1'b1, 1'b1);
    check("reset_beats_all", 32'(outs()), 32'(EXP_RST));
`ifdef HAZARD_STALL_COUNT_EN
    check("count_reset", 32'(stall_count), 32'd0);
`endif
    drive(16'hF050, 16'hF050, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("reset_held_until_edge", 32'(outs()), 32'(EXP_RST));
    tick();
    drive(16'hF050, 16'hF050, 1'b0, 1'b0);
    check("idle", 32'(outs()), 32'(EXP_IDLE));

    drive(16'hF050, 16'hF050, 1'b1, 1'b0);
    check("force_flush", 32'(outs()), 32'(EXP_FLUSH));

    drive(16'hF050, 16'hC000, 1'b0, 1'b0);
    check("stall_op1", 32'(outs()), 32'(EXP_STALL));
    drive(16'hF050, 16'hC100, 1'b0, 1'b0);
    check("no_match_idle", 32'(outs()), 32'(EXP_IDLE));
    drive(16'hF050, 16'hC500, 1'b0, 1'b0);
    check("stall_op2", 32'(outs()), 32'(EXP_STALL));
    drive(16'hF050, 16'hD000, 1'b0, 1'b0);
    check("non_load_idle", 32'(outs()), 32'(EXP_IDLE));

    drive(16'hF050, 16'hF050, 1'b0, 1'b1);
    check("jump", 32'(outs()), 32'(EXP_FLUSH));
    drive(16'hF050, 16'hC000, 1'b0, 1'b1);
    check("stall_beats_jump", 32'(outs()), 32'(EXP_STALL));
    drive(16'hF050, 16'hC000, 1'b1, 1'b1);
    check("flush_beats_stall", 32'(outs()), 32'(EXP_FLUSH));

    drive(16'h0000, 16'hC000, 1'b0, 1'b0);
    check("nop_no_hazard", 32'(outs()), 32'(EXP_IDLE));

    // Reset arriving during a stall takes effect only at the next edge
    drive(16'hF050, 16'hC000, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("stall_before_reset_edge", 32'(outs()), 32'(EXP_STALL));
    tick();
    #1;
    check("reset_mid_stall", 32'(outs()), 32'(EXP_RST));
    reset = 1'b1;
    tick();
    #1;
    check("stall_after_reset", 32'(outs()), 32'(EXP_STALL));
`ifdef HAZARD_STALL_COUNT_EN
    check("count_zero_after_reset", 32'(stall_count), 32'd0);
`endif
    tick();
    tick();
    tick();
    #1;
    check("stall_persists", 32'(outs()), 32'(EXP_STALL));
`ifdef HAZARD_STALL_COUNT_EN
    check("count_three", 32'(stall_count), 32'd3);
`endif
    drive(16'hF050, 16'hC000, 1'b1, 1'b0);
    tick();
    drive(16'hF050, 16'hF050, 1'b0, 1'b1);
    tick();
    #1;
    check("jump_after_flush", 32'(outs()), 32'(EXP_FLUSH));
`ifdef HAZARD_STALL_COUNT_EN
    check("count_not_flush_or_jump", 32'(stall_count), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
